// File: rtl/csr_unit.sv
// Machine-mode CSR file for the RV32 core: CSR read/modify/write,
// counters, FP flags/rounding mode, trap/mret state, interrupt pending.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   csr_valid_i/op/addr/wdata -> csr_rdata_o (old value), csr_illegal_o
//   instret_i           retire strobe for MINSTRET
//   fflags_we_i/fflags_i accrued FPU flags; frm_o current rounding mode
//   trap_i/trap_pc_i/trap_cause_i/trap_tval_i, mret_i  trap entry/exit
//   irq_ext_i/irq_timer_i raw lines; irq_pending_o enabled+pending
//   mtvec_o, mepc_o     trap vector and return address

package csr_pkg;

    typedef enum logic [2:0] {
        NO_CSR_OP = 3'd0,
        WRITE_CSR = 3'd1,
        SET_CSR   = 3'd2,
        CLEAR_CSR = 3'd3,
        SYSTEM    = 3'd4
    } csr_op_e;

    typedef enum logic [11:0] {
        CSR_FFLAGS        = 12'h001,
        CSR_FRM           = 12'h002,
        CSR_FCSR          = 12'h003,
        CSR_MSTATUS       = 12'h300,
        CSR_MISA          = 12'h301,
        CSR_MIE           = 12'h304,
        CSR_MTVEC         = 12'h305,
        CSR_MCOUNTINHIBIT = 12'h320,
        CSR_MSCRATCH      = 12'h340,
        CSR_MEPC          = 12'h341,
        CSR_MCAUSE        = 12'h342,
        CSR_MTVAL         = 12'h343,
        CSR_MIP           = 12'h344,
        CSR_MCYCLE        = 12'hB00,
        CSR_MINSTRET      = 12'hB02,
        CSR_MCYCLEH       = 12'hB80,
        CSR_MINSTRETH     = 12'hB82,
        CSR_CYCLE         = 12'hC00,
        CSR_TIME          = 12'hC01,
        CSR_INSTRET       = 12'hC02,
        CSR_CYCLEH        = 12'hC80,
        CSR_TIMEH         = 12'hC81,
        CSR_INSTRETH      = 12'hC82,
        CSR_MVENDORID     = 12'hF11,
        CSR_MARCHID       = 12'hF12,
        CSR_MIMPID        = 12'hF13,
        CSR_MHARTID       = 12'hF14
    } csr_reg_e;

    typedef enum logic [2:0] {
        RNE = 3'h0,
        RTZ = 3'h1,
        RDN = 3'h2,
        RUP = 3'h3,
        RMM = 3'h4,
        DYN = 3'h7
    } roundmode_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } float_status_e;

endpackage

module csr_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'h0,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_1125,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          csr_valid_i,
    input  csr_op_e       csr_op_i,
    input  csr_reg_e      csr_addr_i,
    input  logic [31:0]   csr_wdata_i,
    output logic [31:0]   csr_rdata_o,
    output logic          csr_illegal_o,
    input  logic          instret_i,
    input  logic          fflags_we_i,
    input  float_status_e fflags_i,
    output roundmode_e    frm_o,
    input  logic          trap_i,
    input  logic [31:0]   trap_pc_i,
    input  logic [31:0]   trap_cause_i,
    input  logic [31:0]   trap_tval_i,
    input  logic          mret_i,
    input  logic          irq_ext_i,
    input  logic          irq_timer_i,
    output logic          irq_pending_o,
    output logic [31:0]   mtvec_o,
    output logic [31:0]   mepc_o
);

    logic [4:0]  fflags_q;
    logic [2:0]  frm_q;
    logic        mie_q;
    logic        mpie_q;
    logic        meie_q;
    logic        mtie_q;
    logic        mip_e_q;
    logic        mip_t_q;
    logic        cy_inh_q;
    logic        ir_inh_q;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;

    logic [31:0] rdata;
    logic        impl;
    logic [31:0] wval;
    logic        ro;
    logic        wr_op;
    logic        sc_op;
    logic        wnz;
    logic        illegal;
    logic        we;
    logic [4:0]  fpu_flags;
    logic [4:0]  fflags_nxt;
    logic [2:0]  frm_nxt;

    always_comb begin
        rdata = '0;
        impl  = 1'b1;
        unique case (csr_addr_i)
            CSR_FFLAGS:    rdata = {27'b0, fflags_q};
            CSR_FRM:       rdata = {29'b0, frm_q};
            CSR_FCSR:      rdata = {24'b0, frm_q, fflags_q};
            CSR_MSTATUS:   rdata = {19'b0, 2'b11, 3'b0, mpie_q,
                                    3'b0, mie_q, 3'b0};
            CSR_MISA:      rdata = MISA_VALUE;
            CSR_MIE:       rdata = {20'b0, meie_q, 3'b0,
                                    mtie_q, 7'b0};
            CSR_MTVEC:     rdata = mtvec_q;
            CSR_MCOUNTINHIBIT:
                           rdata = {29'b0, ir_inh_q, 1'b0, cy_inh_q};
            CSR_MSCRATCH:  rdata = mscratch_q;
            CSR_MEPC:      rdata = mepc_q;
            CSR_MCAUSE:    rdata = mcause_q;
            CSR_MTVAL:     rdata = mtval_q;
            CSR_MIP:       rdata = {20'b0, mip_e_q, 3'b0,
                                    mip_t_q, 7'b0};
            CSR_MCYCLE,
            CSR_CYCLE,
            CSR_TIME:      rdata = mcycle_q[31:0];
            CSR_MCYCLEH,
            CSR_CYCLEH,
            CSR_TIMEH:     rdata = mcycle_q[63:32];
            CSR_MINSTRET,
            CSR_INSTRET:   rdata = minstret_q[31:0];
            CSR_MINSTRETH,
            CSR_INSTRETH:  rdata = minstret_q[63:32];
            CSR_MVENDORID,
            CSR_MARCHID,
            CSR_MIMPID:    rdata = '0;
            CSR_MHARTID:   rdata = HART_ID;
            default:       impl  = 1'b0;
        endcase
    end

    always_comb begin
        wval = rdata;
        case (csr_op_i)
            WRITE_CSR: wval = csr_wdata_i;
            SET_CSR:   wval = rdata | csr_wdata_i;
            CLEAR_CSR: wval = rdata & ~csr_wdata_i;
            default:   wval = rdata;
        endcase
    end

    // SET/CLEAR with a zero mask is a pure read: legal on read-only
    // space and it must not count as a write (counter increments stay).
    assign ro      = csr_addr_i[11:10] == 2'b11;
    assign wr_op   = csr_op_i == WRITE_CSR;
    assign sc_op   = (csr_op_i == SET_CSR) || (csr_op_i == CLEAR_CSR);
    assign wnz     = |csr_wdata_i;
    assign illegal = ~impl | (ro & (wr_op | (sc_op & wnz)));
    assign we      = csr_valid_i & (wr_op | (sc_op & wnz)) & ~illegal
                   & ~trap_i & ~mret_i;

    assign csr_rdata_o   = rdata;
    assign csr_illegal_o = csr_valid_i & illegal;

    assign fpu_flags = fflags_i & {5{fflags_we_i}};

    always_comb begin
        fflags_nxt = fflags_q;
        frm_nxt    = frm_q;
        if (we && csr_addr_i == CSR_FFLAGS) fflags_nxt = wval[4:0];
        if (we && csr_addr_i == CSR_FCSR)   fflags_nxt = wval[4:0];
        if (we && csr_addr_i == CSR_FRM)    frm_nxt    = wval[2:0];
        if (we && csr_addr_i == CSR_FCSR)   frm_nxt    = wval[7:5];
        fflags_nxt = fflags_nxt | fpu_flags;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fflags_q <= '0;
            frm_q    <= '0;
            mip_e_q  <= 1'b0;
            mip_t_q  <= 1'b0;
        end else begin
            fflags_q <= fflags_nxt;
            frm_q    <= frm_nxt;
            mip_e_q  <= irq_ext_i;
            mip_t_q  <= irq_timer_i;
        end
    end

    // A write to either half replaces it and takes this cycle's tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (we && csr_addr_i == CSR_MCYCLE)
                mcycle_q[31:0] <= wval;
            else if (we && csr_addr_i == CSR_MCYCLEH)
                mcycle_q[63:32] <= wval;
            else if (!cy_inh_q)
                mcycle_q <= mcycle_q + 64'd1;

            if (we && csr_addr_i == CSR_MINSTRET)
                minstret_q[31:0] <= wval;
            else if (we && csr_addr_i == CSR_MINSTRETH)
                minstret_q[63:32] <= wval;
            else if (instret_i && !ir_inh_q)
                minstret_q <= minstret_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            meie_q     <= 1'b0;
            mtie_q     <= 1'b0;
            cy_inh_q   <= 1'b0;
            ir_inh_q   <= 1'b0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (trap_i) begin
            mepc_q   <= trap_pc_i & ~32'h3;
            mcause_q <= trap_cause_i;
            mtval_q  <= trap_tval_i;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
        end else if (mret_i) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end else if (we) begin
            case (csr_addr_i)
                CSR_MSTATUS: begin
                    mie_q  <= wval[3];
                    mpie_q <= wval[7];
                end
                CSR_MIE: begin
                    meie_q <= wval[11];
                    mtie_q <= wval[7];
                end
                CSR_MCOUNTINHIBIT: begin
                    cy_inh_q <= wval[0];
                    ir_inh_q <= wval[2];
                end
                CSR_MTVEC:    mtvec_q    <= wval & ~32'h3;
                CSR_MSCRATCH: mscratch_q <= wval;
                CSR_MEPC:     mepc_q     <= wval & ~32'h3;
                CSR_MCAUSE:   mcause_q   <= wval;
                CSR_MTVAL:    mtval_q    <= wval;
                default: ;
            endcase
        end
    end

    assign frm_o         = roundmode_e'(frm_q);
    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;
    assign irq_pending_o = mie_q & ((mip_e_q & meie_q) | (mip_t_q & mtie_q));

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: stimulus queues expected outputs,
// a monitor pops and compares them mid low-phase each cycle.

module tb_csr_unit;
    import csr_pkg::*;

    localparam logic [31:0] HID  = 32'h0000_0005;
    localparam logic [31:0] MTVR = 32'h0000_0100;

    typedef enum int {K_RDATA, K_ILL, K_PEND, K_MEPC, K_MTVEC, K_FRM} kind_e;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          csr_valid_i;
    csr_op_e       csr_op_i;
    csr_reg_e      csr_addr_i;
    logic [31:0]   csr_wdata_i;
    logic [31:0]   csr_rdata_o;
    logic          csr_illegal_o;
    logic          instret_i;
    logic          fflags_we_i;
    float_status_e fflags_i;
    roundmode_e    frm_o;
    logic          trap_i;
    logic [31:0]   trap_pc_i;
    logic [31:0]   trap_cause_i;
    logic [31:0]   trap_tval_i;
    logic          mret_i;
    logic          irq_ext_i;
    logic          irq_timer_i;
    logic          irq_pending_o;
    logic [31:0]   mtvec_o;
    logic [31:0]   mepc_o;

    csr_unit #(
        .HART_ID     (HID),
        .MISA_VALUE  (32'h4000_1125),
        .MTVEC_RESET (MTVR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .csr_valid_i   (csr_valid_i),
        .csr_op_i      (csr_op_i),
        .csr_addr_i    (csr_addr_i),
        .csr_wdata_i   (csr_wdata_i),
        .csr_rdata_o   (csr_rdata_o),
        .csr_illegal_o (csr_illegal_o),
        .instret_i     (instret_i),
        .fflags_we_i   (fflags_we_i),
        .fflags_i      (fflags_i),
        .frm_o         (frm_o),
        .trap_i        (trap_i),
        .trap_pc_i     (trap_pc_i),
        .trap_cause_i  (trap_cause_i),
        .trap_tval_i   (trap_tval_i),
        .mret_i        (mret_i),
        .irq_ext_i     (irq_ext_i),
        .irq_timer_i   (irq_timer_i),
        .irq_pending_o (irq_pending_o),
        .mtvec_o       (mtvec_o),
        .mepc_o        (mepc_o)
    );

    always #5 clk = ~clk;

    kind_e       kind_q[$];
    logic [31:0] val_q[$];
    string       name_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic put(input kind_e k, input logic [31:0] v,
                       input string nm);
        kind_q.push_back(k);
        val_q.push_back(v);
        name_q.push_back(nm);
    endtask

    // Monitor: compares every queued expectation against the live
    // outputs half-way through the low phase.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            while (kind_q.size() > 0) begin
                kind_e       k;
                logic [31:0] e;
                logic [31:0] a;
                string       nm;
                k  = kind_q.pop_front();
                e  = val_q.pop_front();
                nm = name_q.pop_front();
                case (k)
                    K_RDATA: a = csr_rdata_o;
                    K_ILL:   a = {31'b0, csr_illegal_o};
                    K_PEND:  a = {31'b0, irq_pending_o};
                    K_MEPC:  a = mepc_o;
                    K_MTVEC: a = mtvec_o;
                    default: a = {29'b0, frm_o};
                endcase
                n_vec++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL %s: got %h, want %h", nm, a, e);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        csr_valid_i = 1'b0;
        csr_op_i    = NO_CSR_OP;
        csr_wdata_i = '0;
        trap_i      = 1'b0;
        mret_i      = 1'b0;
        fflags_we_i = 1'b0;
        fflags_i    = '0;
        instret_i   = 1'b0;
    endtask

    task automatic req(input csr_op_e op, input logic [11:0] a,
                       input logic [31:0] wd);
        csr_valid_i = 1'b1;
        csr_op_i    = op;
        csr_addr_i  = csr_reg_e'(a);
        csr_wdata_i = wd;
    endtask

    task automatic rd(input csr_op_e op, input logic [11:0] a,
                      input logic [31:0] wd, input logic [31:0] e,
                      input string nm);
        req(op, a, wd);
        put(K_RDATA, e, nm);
        put(K_ILL, 32'd0, {nm, "_ill"});
        tick();
    endtask

    task automatic ill(input csr_op_e op, input logic [11:0] a,
                       input logic [31:0] wd, input string nm);
        req(op, a, wd);
        put(K_ILL, 32'd1, nm);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        csr_valid_i  = 1'b0;
        csr_op_i     = NO_CSR_OP;
        csr_addr_i   = CSR_MSTATUS;
        csr_wdata_i  = '0;
        instret_i    = 1'b0;
        fflags_we_i  = 1'b0;
        fflags_i     = '0;
        trap_i       = 1'b0;
        trap_pc_i    = '0;
        trap_cause_i = '0;
        trap_tval_i  = '0;
        mret_i       = 1'b0;
        irq_ext_i    = 1'b0;
        irq_timer_i  = 1'b0;

        // reset state
        tick();
        tick();
        put(K_PEND, 32'd0, "rst_pend");
        put(K_FRM, 32'd0, "rst_frm");
        put(K_MEPC, 32'd0, "rst_mepc");
        put(K_ILL, 32'd0, "rst_ill");
        tick();
        rst_n = 1'b1;
        put(K_MTVEC, MTVR, "rst_mtvec");
        rd(SET_CSR, 12'hB00, 0, 32'd0, "mcycle_0");
        rd(SET_CSR, 12'h300, 0, 32'h1800, "mstatus_rst");
        rd(SET_CSR, 12'hB00, 0, 32'd2, "mcycle_2");

        // read-modify-write
        rd(WRITE_CSR, 12'h340, 32'hA5A5_0F0F, 32'h0, "scr_w");
        rd(SET_CSR, 12'h340, 32'h0000_F000, 32'hA5A5_0F0F, "scr_s");
        rd(CLEAR_CSR, 12'h340, 32'hA000_0000, 32'hA5A5_FF0F, "scr_c");
        rd(SET_CSR, 12'h340, 0, 32'h05A5_FF0F, "scr_fin");

        // trap / mret, same-cycle CSR writes dropped
        rd(WRITE_CSR, 12'h300, 32'h8, 32'h1800, "mst_mie");
        trap_i       = 1'b1;
        trap_pc_i    = 32'h8000_0102;
        trap_cause_i = 32'h8000_000B;
        trap_tval_i  = 32'h0000_1234;
        rd(WRITE_CSR, 12'h340, 32'hDEAD_BEEF, 32'h05A5_FF0F, "trap_rd");
        put(K_MEPC, 32'h8000_0100, "mepc_o");
        rd(SET_CSR, 12'h341, 0, 32'h8000_0100, "mepc");
        rd(SET_CSR, 12'h300, 0, 32'h1880, "mst_trap");
        rd(SET_CSR, 12'h342, 0, 32'h8000_000B, "mcause");
        rd(SET_CSR, 12'h343, 0, 32'h0000_1234, "mtval");
        rd(SET_CSR, 12'h340, 0, 32'h05A5_FF0F, "scr_trap");
        mret_i = 1'b1;
        rd(WRITE_CSR, 12'h340, 32'h1, 32'h05A5_FF0F, "mret_rd");
        rd(SET_CSR, 12'h300, 0, 32'h1888, "mst_mret");
        rd(SET_CSR, 12'h340, 0, 32'h05A5_FF0F, "scr_mret");

        // legality
        req(WRITE_CSR, 12'hF11, 32'h5);
        put(K_RDATA, 32'h0, "mvid_rd");
        ill(WRITE_CSR, 12'hF11, 32'h5, "mvid_w");
        rd(SET_CSR, 12'hF14, 0, HID, "mhartid");
        ill(SET_CSR, 12'h7C0, 0, "unimpl");
        ill(SET_CSR, 12'hC00, 32'h1, "cycle_set");
        rd(WRITE_CSR, 12'h301, 0, 32'h4000_1125, "misa_w");
        rd(SET_CSR, 12'h301, 0, 32'h4000_1125, "misa");
        rd(WRITE_CSR, 12'h305, 32'h1003, MTVR, "mtvec_w");
        put(K_MTVEC, 32'h1000, "mtvec_o");
        rd(SET_CSR, 12'h305, 0, 32'h1000, "mtvec_warl");

        // 64-bit cycle counter wrap and inhibit
        req(WRITE_CSR, 12'hB00, 32'hFFFF_FFFF);
        tick();
        rd(WRITE_CSR, 12'hB80, 32'hFFFF_FFFF, 32'h0, "mcych_w");
        rd(SET_CSR, 12'hB00, 0, 32'hFFFF_FFFF, "mcyc_max");
        rd(SET_CSR, 12'hB80, 0, 32'h0, "mcych_wrap");
        rd(SET_CSR, 12'hC00, 0, 32'h1, "cycle_1");
        rd(WRITE_CSR, 12'h320, 32'h1, 32'h0, "inh_w");
        rd(SET_CSR, 12'hB00, 0, 32'h3, "inh_a");
        rd(SET_CSR, 12'hB00, 0, 32'h3, "inh_b");
        rd(WRITE_CSR, 12'h320, 32'h0, 32'h1, "inh_clr");
        rd(SET_CSR, 12'hB00, 0, 32'h3, "inh_c");
        rd(SET_CSR, 12'hB00, 0, 32'h4, "inh_run");

        // instret
        instret_i = 1'b1;
        rd(SET_CSR, 12'hC02, 0, 32'd0, "ir_0");
        instret_i = 1'b1;
        rd(SET_CSR, 12'hC02, 0, 32'd1, "ir_1");
        instret_i = 1'b1;
        rd(SET_CSR, 12'hC02, 0, 32'd2, "ir_2");
        instret_i = 1'b1;
        rd(WRITE_CSR, 12'hB02, 32'd10, 32'd3, "ir_w");
        rd(SET_CSR, 12'hB02, 0, 32'd10, "ir_10");
        rd(SET_CSR, 12'hB82, 0, 32'd0, "irh");

        // FP flags and rounding mode
        fflags_we_i = 1'b1;
        fflags_i    = float_status_e'(5'h01);
        rd(SET_CSR, 12'h001, 0, 32'h0, "ff_0");
        fflags_we_i = 1'b1;
        fflags_i    = float_status_e'(5'h08);
        rd(WRITE_CSR, 12'h001, 32'h10, 32'h01, "ff_w");
        rd(SET_CSR, 12'h001, 0, 32'h18, "ff_18");
        rd(WRITE_CSR, 12'h002, 32'hB, 32'h0, "frm_w");
        put(K_FRM, 32'd3, "frm_o");
        rd(SET_CSR, 12'h003, 0, 32'h78, "fcsr");

        // interrupts
        rd(WRITE_CSR, 12'h304, 32'h800, 32'h0, "mie_w");
        irq_ext_i = 1'b1;
        put(K_PEND, 32'd0, "pend_0");
        tick();
        put(K_PEND, 32'd1, "pend_1");
        rd(SET_CSR, 12'h344, 0, 32'h800, "mip");
        put(K_PEND, 32'd1, "pend_hold");
        rd(CLEAR_CSR, 12'h300, 32'h8, 32'h1888, "mst_clr");
        put(K_PEND, 32'd0, "pend_drop");
        tick();
        irq_ext_i = 1'b0;

        // reset asserted mid-write discards the update
        req(WRITE_CSR, 12'h340, 32'h1234);
        #1 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        put(K_MTVEC, MTVR, "rst2_mtvec");
        put(K_PEND, 32'd0, "rst2_pend");
        put(K_FRM, 32'd0, "rst2_frm");
        put(K_MEPC, 32'd0, "rst2_mepc");
        rd(SET_CSR, 12'h340, 0, 32'h0, "rst2_scr");
        rd(SET_CSR, 12'h300, 0, 32'h1800, "rst2_mst");

        tick();
        tick();
        if (kind_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d left, want 0", kind_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
